// File: rtl/key_pkg.sv
// Shared types and default timing for the push-button conditioning chain.
// The repeat-state encoding is fixed so other blocks can decode it.
package key_pkg;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_DELAY  = 2'd1,
        KS_REPEAT = 2'd2
    } key_state_e;

    localparam int KEY_NUM_KEYS_DEFAULT    = 4;
    localparam int KEY_DEBOUNCE_DEFAULT    = 1_000_000;
    localparam int KEY_REPEAT_DELAY_DEFAULT = 25_000_000;
    localparam int KEY_REPEAT_RATE_DEFAULT  = 5_000_000;

    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchroniser, counter debouncer, edge pulses
// and the per-key auto-repeat state machine. All outputs come straight from flops.
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = KEY_REPEAT_RATE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    input  logic repeat_en_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic key_repeat_o
);

    localparam int DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic              sync1_q, sync2_q;
    logic              sample;
    logic              level_q, level_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              rise, fall;
    key_state_e        rstate_q, rstate_d;
    logic [RPT_W-1:0]  rcnt_q, rcnt_d;
    logic              repeat_d;
    logic              press_q, release_q, repeat_q;

    // Synchronisers reset to the released (high) level of the raw button.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            level_q   <= 1'b0;
            db_cnt_q  <= '0;
            rstate_q  <= KS_IDLE;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            sync1_q   <= key_n_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            db_cnt_q  <= db_cnt_d;
            rstate_q  <= rstate_d;
            rcnt_q    <= rcnt_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= repeat_d;
        end
    end

    assign sample = ~sync2_q;

    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        rise     = 1'b0;
        fall     = 1'b0;
        if (sample != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sample;
                rise    = sample;
                fall    = ~sample;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // A release (or dropping repeat_en) pre-empts any tick due in the same cycle.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        repeat_d = 1'b0;
        case (rstate_q)
            KS_IDLE: begin
                if (rise) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                    if (repeat_en_i) begin
                        rstate_d = KS_DELAY;
                    end
                end
            end
            KS_DELAY: begin
                if (fall || !repeat_en_i) begin
                    rstate_d = KS_IDLE;
                    rcnt_d   = '0;
                end else if (rcnt_q == DELAY_LAST) begin
                    rstate_d = KS_REPEAT;
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
            end
            KS_REPEAT: begin
                if (fall || !repeat_en_i) begin
                    rstate_d = KS_IDLE;
                    rcnt_d   = '0;
                end else if (rcnt_q == RATE_LAST) begin
                    repeat_d = 1'b1;
                    rcnt_d   = '0;
                end else begin
                    rcnt_d = rcnt_q + RPT_W'(1);
                end
            end
            default: begin
                rstate_d = KS_IDLE;
                rcnt_d   = '0;
            end
        endcase
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign key_repeat_o  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low KEY buttons into debounced, active-high levels,
// press/release pulses and auto-repeat pulses for the game logic downstream.
module key_conditioner
    import key_pkg::*;
#(
    parameter int NUM_KEYS        = KEY_NUM_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_RATE     = KEY_REPEAT_RATE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                any_held
);

    logic any_held_q;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_chan (
            .clk           (clk),
            .rst           (rst),
            .key_n_i       (key_n_in[k]),
            .repeat_en_i   (repeat_en[k]),
            .key_level_o   (key_level[k]),
            .key_press_o   (key_press[k]),
            .key_release_o (key_release[k]),
            .key_repeat_o  (key_repeat[k])
        );
    end

    // Built from the registered levels, so it trails key_level by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            any_held_q <= 1'b0;
        end else begin
            any_held_q <= |key_level;
        end
    end

    assign any_held = any_held_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timing.
module tb_key_conditioner;

    localparam int NK = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_repeat;
    logic          any_held;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n_in    (key_n_in),
        .repeat_en   (repeat_en),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_repeat  (key_repeat),
        .any_held    (any_held)
    );

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_n_in = '1;
        repeat_en = '0;
        tick(); tick(); tick();
        checks++; if (key_level !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b expected 0000", key_level); end
        checks++; if (key_press !== 4'b0000) begin errors++; $display("FAIL reset_press: got %b expected 0000", key_press); end
        checks++; if (key_release !== 4'b0000) begin errors++; $display("FAIL reset_release: got %b expected 0000", key_release); end
        checks++; if (key_repeat !== 4'b0000) begin errors++; $display("FAIL reset_repeat: got %b expected 0000", key_repeat); end
        checks++; if (any_held !== 1'b0) begin errors++; $display("FAIL reset_any_held: got %b expected 0", any_held); end
        rst = 1'b0;
        tick(); tick(); tick();
        checks++; if (key_level !== 4'b0000 || any_held !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: got level=%b any=%b expected 0000/0", key_level, any_held);
        end
    endtask

    task automatic test_bounce();
        int rise_at, presses, rel_at, rels;
        key_n_in[0] = 1'b0;
        tick(); tick();
        key_n_in[0] = 1'b1;
        tick();
        key_n_in[0] = 1'b0;
        rise_at = -1; presses = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_press[0]) presses++;
            if (key_level[0] && rise_at < 0) rise_at = i;
        end
        checks++; if (rise_at != 6) begin errors++; $display("FAIL bounce_rise_cycle: got %0d expected 6", rise_at); end
        checks++; if (presses != 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", presses); end
        key_n_in[0] = 1'b1;
        rel_at = -1; rels = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_release[0]) begin rels++; if (rel_at < 0) rel_at = i; end
        end
        checks++; if (rel_at != 6) begin errors++; $display("FAIL bounce_release_cycle: got %0d expected 6", rel_at); end
        checks++; if (rels != 1) begin errors++; $display("FAIL bounce_release_count: got %0d expected 1", rels); end
        checks++; if (key_level[0] !== 1'b0) begin errors++; $display("FAIL bounce_level_after: got %b expected 0", key_level[0]); end
    endtask

    task automatic test_glitch();
        logic [3:0] seen;
        key_n_in[1] = 1'b0;
        tick(); tick(); tick();
        key_n_in[1] = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= {key_level[1], key_press[1], key_release[1], key_repeat[1]};
        end
        checks++; if (seen !== 4'b0000) begin
            errors++; $display("FAIL glitch_rejected: got lvl/prs/rel/rpt=%b expected 0000", seen);
        end
    endtask

    task automatic test_repeat();
        int  p_at;
        logic exp_rep, exp_rel;
        repeat_en[1] = 1'b1;
        key_n_in[1] = 1'b0;
        p_at = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (key_press[1]) begin p_at = i; break; end
        end
        checks++; if (p_at != 6) begin errors++; $display("FAIL repeat_press_cycle: got %0d expected 6", p_at); end
        checks++; if (key_repeat[1] !== 1'b1) begin errors++; $display("FAIL repeat_with_press: got %b expected 1", key_repeat[1]); end
        for (int off = 1; off <= 45; off++) begin
            tick();
            exp_rep = (off < 36) && (off == 10 || (off > 10 && ((off - 10) % 3) == 0));
            exp_rel = (off == 36);
            checks++; if (key_repeat[1] !== exp_rep) begin
                errors++; $display("FAIL repeat_tick_P+%0d: got %b expected %b", off, key_repeat[1], exp_rep);
            end
            checks++; if (key_release[1] !== exp_rel) begin
                errors++; $display("FAIL repeat_release_P+%0d: got %b expected %b", off, key_release[1], exp_rel);
            end
            if (off == 30) key_n_in[1] = 1'b1;
        end
        repeat_en[1] = 1'b0;
    endtask

    task automatic test_no_repeat();
        int reps, presses, coinc_bad;
        repeat_en[2] = 1'b0;
        key_n_in[2] = 1'b0;
        reps = 0; presses = 0; coinc_bad = 0;
        for (int i = 1; i <= 46; i++) begin
            tick();
            if (key_repeat[2]) reps++;
            if (key_press[2]) presses++;
            if (key_repeat[2] !== key_press[2]) coinc_bad++;
        end
        checks++; if (reps != 1) begin errors++; $display("FAIL norepeat_count: got %0d expected 1", reps); end
        checks++; if (presses != 1) begin errors++; $display("FAIL norepeat_press_count: got %0d expected 1", presses); end
        checks++; if (coinc_bad != 0) begin errors++; $display("FAIL norepeat_coincident: got %0d stray cycles expected 0", coinc_bad); end
        key_n_in[2] = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (key_level[2] !== 1'b0) begin errors++; $display("FAIL norepeat_released: got %b expected 0", key_level[2]); end
    endtask

    task automatic test_simultaneous();
        int found;
        logic [3:0] got;
        key_n_in[0] = 1'b0;
        key_n_in[3] = 1'b0;
        found = -1; got = '0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_press != 4'b0000) begin found = i; got = key_press; break; end
        end
        checks++; if (got !== 4'b1001) begin errors++; $display("FAIL simul_press: got %b expected 1001", got); end
        checks++; if (found != 6) begin errors++; $display("FAIL simul_press_cycle: got %0d expected 6", found); end
        checks++; if (any_held !== 1'b0) begin errors++; $display("FAIL simul_any_held_lag: got %b expected 0", any_held); end
        tick();
        checks++; if (any_held !== 1'b1) begin errors++; $display("FAIL simul_any_held: got %b expected 1", any_held); end
        checks++; if (key_press !== 4'b0000) begin errors++; $display("FAIL simul_press_one_cycle: got %b expected 0000", key_press); end
        key_n_in = '1;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (key_level !== 4'b0000 || any_held !== 1'b0) begin
            errors++; $display("FAIL simul_release_all: got level=%b any=%b expected 0000/0", key_level, any_held);
        end
    endtask

    task automatic test_reset_mid_hold();
        int found, early;
        repeat_en[0] = 1'b1;
        key_n_in[0] = 1'b0;
        found = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_press[0]) begin found = i; break; end
        end
        checks++; if (found != 6) begin errors++; $display("FAIL midrst_first_press: got %0d expected 6", found); end
        for (int off = 1; off <= 11; off++) begin
            tick();
            if (off == 10) begin
                checks++; if (key_repeat[0] !== 1'b1) begin errors++; $display("FAIL midrst_repeat_running: got %b expected 1", key_repeat[0]); end
            end
        end
        rst = 1'b1;
        tick();
        checks++; if ({key_level, key_press, key_release, key_repeat, any_held} !== 17'd0) begin
            errors++; $display("FAIL midrst_outputs_zero: got lvl=%b prs=%b rel=%b rpt=%b any=%b expected all 0",
                               key_level, key_press, key_release, key_repeat, any_held);
        end
        rst = 1'b0;
        found = -1; early = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (key_press[0]) begin found = i; break; end
            if (key_level[0]) early++;
        end
        checks++; if (found != 6) begin errors++; $display("FAIL midrst_repress_cycle: got %0d expected 6", found); end
        checks++; if (early != 0) begin errors++; $display("FAIL midrst_level_early: got %0d cycles expected 0", early); end
        checks++; if (key_repeat[0] !== 1'b1) begin errors++; $display("FAIL midrst_repeat_with_press: got %b expected 1", key_repeat[0]); end
        key_n_in = '1;
        repeat_en = '0;
        for (int i = 0; i < 10; i++) tick();
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_glitch();
        test_repeat();
        test_no_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
